// File: rtl/mem_responder.sv
// Memory-side responder for the request/grant/valid protocol: delayed grants, byte-enabled
// writes to a local word array and a fixed-latency response pipeline.
`timescale 1ns / 1ps

module mem_responder #(
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned GNT_DELAY    = 0,
  parameter int unsigned RESP_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic [WORD_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  input  logic                  stall_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int unsigned AddrBits = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW     = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
  localparam int unsigned Lanes    = (WORD_WIDTH / 8 < 4) ? WORD_WIDTH / 8 : 4;

  logic [CntW-1:0]       wcnt_q;
  logic                  cnt_done;
  logic                  xfer;
  logic                  in_range;
  logic [AddrBits-1:0]   idx;
  logic [WORD_WIDTH-1:0] s0_data;
  logic                  unused_addr;

  logic [WORD_WIDTH-1:0] mem_q   [DEPTH_WORDS];
  logic                  valid_q [RESP_LATENCY];
  logic [WORD_WIDTH-1:0] data_q  [RESP_LATENCY];
  logic                  err_q   [RESP_LATENCY];

  assign cnt_done    = (wcnt_q == CntW'(GNT_DELAY));
  assign gnt_o       = rst_n & req_i & ~stall_i & cnt_done;
  assign xfer        = req_i & gnt_o;
  assign idx         = addr_i[AddrBits+1:2];
  // Power-of-two depth: in range iff every bit above the word index is clear.
  assign in_range    = ~|addr_i[WORD_WIDTH-1:AddrBits+2];
  assign unused_addr = ^addr_i[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
    end else if (!req_i || gnt_o) begin
      wcnt_q <= '0;
    end else if (!stall_i && !cnt_done) begin
      wcnt_q <= wcnt_q + 1'b1;
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (xfer && we_i && in_range) begin
      for (int unsigned k = 0; k < Lanes; k++) begin
        if (be_i[k]) begin
          mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    s0_data = '0;
    if (xfer && !we_i && in_range) begin
      s0_data = mem_q[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RESP_LATENCY; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        err_q[i]   <= 1'b0;
      end
    end else begin
      valid_q[0] <= xfer;
      data_q[0]  <= s0_data;
      err_q[0]   <= xfer & ~in_range;
      for (int unsigned i = 1; i < RESP_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
        err_q[i]   <= err_q[i-1];
      end
    end
  end

  assign rvalid_o = valid_q[RESP_LATENCY-1];
  assign rdata_o  = data_q[RESP_LATENCY-1];
  assign err_o    = err_q[RESP_LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: two responders (immediate grant / delayed grant with deep pipeline) driven by
// random traffic; expected responses come from a word-array model and are checked by a monitor.
`timescale 1ns / 1ps

module tb_mem_responder;

  localparam int G0 = 0;
  localparam int L0 = 1;
  localparam int G1 = 3;
  localparam int L1 = 3;
  localparam int Depth = 64;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req    [2];
  logic        we     [2];
  logic [31:0] addr   [2];
  logic [3:0]  be     [2];
  logic [31:0] wdata  [2];
  logic        stall  [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];

  logic [31:0] model [2][Depth];
  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  mem_responder #(
    .WORD_WIDTH(32), .DEPTH_WORDS(Depth), .GNT_DELAY(G0), .RESP_LATENCY(L0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]),
    .wdata_i(wdata[0]), .stall_i(stall[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0])
  );

  mem_responder #(
    .WORD_WIDTH(32), .DEPTH_WORDS(Depth), .GNT_DELAY(G1), .RESP_LATENCY(L1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]),
    .wdata_i(wdata[1]), .stall_i(stall[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gdelay(input int p);
    return (p == 0) ? G0 : G1;
  endfunction

  function automatic int rlat(input int p);
    return (p == 0) ? L0 : L1;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic q_push(input int p, input exp_t e);
    if (p == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic q_pop(input int p, output exp_t e);
    if (p == 0) e = q0.pop_front();
    else e = q1.pop_front();
  endtask

  function automatic int q_size(input int p);
    return (p == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int q_front_due(input int p);
    return (p == 0) ? q0[0].due : q1[0].due;
  endfunction

  // Reference behaviour of one accepted transfer: update the array, queue the response.
  task automatic model_xfer(input int p, input bit w, input logic [31:0] a, input logic [3:0] b,
                            input logic [31:0] wd);
    exp_t        e;
    bit          in_r;
    logic [5:0]  wi;
    in_r   = (a < Depth * 4);
    wi     = a[7:2];
    e.due  = cyc + rlat(p);
    e.err  = !in_r;
    e.data = 32'h0;
    if (w) begin
      if (in_r)
        for (int k = 0; k < 4; k++)
          if (b[k]) model[p][wi][8*k +: 8] = wd[8*k +: 8];
    end else if (in_r) begin
      e.data = model[p][wi];
    end
    q_push(p, e);
  endtask

  // Grant is expected on the first unstalled cycle preceded by exactly gdelay unstalled cycles.
  task automatic xfer(input int p, input bit w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] wd, input int stall_pct);
    int unst   = 0;
    int waited = 0;
    bit done   = 0;
    bit exp_g;
    @(posedge clk);
    #1;
    req[p]   = 1'b1;
    we[p]    = w;
    addr[p]  = a;
    be[p]    = b;
    wdata[p] = wd;
    stall[p] = ($urandom_range(99) < stall_pct);
    while (!done) begin
      @(negedge clk);
      exp_g = !stall[p] && (unst == gdelay(p));
      check(gnt[p] === exp_g, "gnt_timing", {31'h0, gnt[p]}, {31'h0, exp_g});
      if (gnt[p] === 1'b1) begin
        model_xfer(p, w, a, b, wd);
        done = 1;
      end else begin
        if (!stall[p]) unst++;
        waited++;
        if (waited > 60) begin
          check(1'b0, "gnt_timeout", 32'(waited), 32'(gdelay(p)));
          done = 1;
        end else begin
          @(posedge clk);
          #1;
          stall[p] = ($urandom_range(99) < stall_pct);
        end
      end
    end
  endtask

  task automatic idle(input int p, input int n);
    @(posedge clk);
    #1;
    req[p]   = 1'b0;
    stall[p] = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  // Request raised for fewer cycles than the grant delay, then dropped: no grant, no transfer.
  task automatic withdraw(input int p);
    int n;
    n = $urandom_range(1, gdelay(p));
    @(posedge clk);
    #1;
    req[p]   = 1'b1;
    we[p]    = 1'b1;
    addr[p]  = 32'h0;
    be[p]    = 4'hF;
    wdata[p] = $urandom;
    stall[p] = 1'b0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      check(gnt[p] === 1'b0, "withdraw_gnt", {31'h0, gnt[p]}, 32'h0);
      if (j < n - 1) @(posedge clk);
    end
    idle(p, 1);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(99);
    if (r < 60) return 32'($urandom_range(0, 7) * 4);
    else if (r < 90) return 32'($urandom_range(0, Depth - 1) * 4 + $urandom_range(0, 3));
    else return 32'h100 + ($urandom & 32'hFFFF);
  endfunction

  task automatic preload(input int p);
    logic [31:0] d;
    for (int i = 0; i < Depth; i++) begin
      d = $urandom;
      if (p == 0 && i == 4) d = 32'hDEADBEEF;
      if (p == 0 && i == 8) d = 32'hAABBCCDD;
      if (p == 1 && i < 4) d = 32'(i);
      xfer(p, 1'b1, 32'(i * 4), 4'hF, d, 0);
    end
    idle(p, 2);
  endtask

  task automatic rand_seq(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      xfer(p, 1'($urandom_range(1)), rand_addr(), 4'($urandom_range(15)), $urandom, 20);
      if ($urandom_range(99) < 40) idle(p, $urandom_range(1, 3));
      if (p == 1 && $urandom_range(99) < 10) withdraw(p);
    end
    idle(p, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    check(q0.size() == 0 && q1.size() == 0, "drain", 32'(q0.size() + q1.size()), 32'h0);
  endtask

  task automatic monitor(input int p);
    exp_t e;
    if (rvalid[p] === 1'b1) begin
      if (q_size(p) == 0) begin
        check(1'b0, "unexpected_rvalid", rdata[p], 32'h0);
      end else begin
        q_pop(p, e);
        check(cyc == e.due, "resp_latency", 32'(cyc), 32'(e.due));
        check(rdata[p] === e.data, "rdata", rdata[p], e.data);
        check(err[p] === e.err, "err", {31'h0, err[p]}, {31'h0, e.err});
      end
    end else begin
      check(rdata[p] === 32'h0 && err[p] === 1'b0, "idle_outputs", rdata[p], 32'h0);
      if (q_size(p) != 0 && q_front_due(p) <= cyc) begin
        q_pop(p, e);
        check(1'b0, "missing_rvalid", 32'(cyc), 32'(e.due));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      monitor(0);
      monitor(1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; be[p] = '0; wdata[p] = '0; stall[p] = 1'b0;
    end
    req[0] = 1'b1;
    #12;
    for (int p = 0; p < 2; p++) begin
      check(gnt[p] === 1'b0, "reset_gnt", {31'h0, gnt[p]}, 32'h0);
      check(rvalid[p] === 1'b0, "reset_rvalid", {31'h0, rvalid[p]}, 32'h0);
      check(rdata[p] === 32'h0 && err[p] === 1'b0, "reset_rdata", rdata[p], 32'h0);
    end
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    fork
      begin
        preload(0);
        xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, 0);
        idle(0, 2);
        xfer(0, 1'b1, 32'h20, 4'b0101, 32'h11223344, 0);
        xfer(0, 1'b0, 32'h20, 4'h0, 32'h0, 0);
        idle(0, 2);
        xfer(0, 1'b0, 32'h1000, 4'h0, 32'h0, 0);
        xfer(0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 0);
        xfer(0, 1'b0, 32'h0, 4'h0, 32'h0, 0);
        idle(0, 2);
        rand_seq(0, 300);
      end
      begin
        preload(1);
        for (int i = 0; i < 4; i++) xfer(1, 1'b0, 32'(i * 4), 4'h0, 32'h0, 0);
        idle(1, 2);
        withdraw(1);
        xfer(1, 1'b0, 32'h4, 4'h0, 32'h0, 50);
        idle(1, 1);
        rand_seq(1, 200);
      end
    join
    drain();

    // Reset while a read response is still inside the pipeline.
    xfer(1, 1'b0, 32'h8, 4'h0, 32'h0, 0);
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    check(rvalid[1] === 1'b0, "rst_rvalid_drop", {31'h0, rvalid[1]}, 32'h0);
    check(rdata[1] === 32'h0, "rst_rdata_drop", rdata[1], 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < L1 + 3; i++) begin
      @(negedge clk);
      check(rvalid[1] === 1'b0, "stale_rvalid", {31'h0, rvalid[1]}, 32'h0);
    end

    fork
      begin
        xfer(1, 1'b0, 32'h8, 4'h0, 32'h0, 0);
        idle(1, 1);
      end
      begin
        xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, 0);
        idle(0, 1);
      end
    join
    drain();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
